// File: rtl/box_drawer_pkg.sv
// Purpose: shared game constants, FSM state type and screen-bounds helper for the box painter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package box_drawer_pkg;

    // Visible VGA raster and colour depth used by the rocket, asteroid and erase paths
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOR_W  = 3;

    // Coordinate widths on the VGA adapter interface
    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Pixel coordinate sums carry one extra bit so a box hanging off the
    // right or bottom edge never wraps back onto column 0 or row 0.
    typedef struct packed {
        logic [X_W:0] x;
        logic [Y_W:0] y;
    } pix_sum_t;

    // Counter width for a box dimension; a 1-pixel side still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when the unwrapped pixel lies on the visible screen.
    function automatic logic on_screen(input pix_sum_t p);
        return (p.x < (X_W+1)'(SCREEN_W)) && (p.y < (Y_W+1)'(SCREEN_H));
    endfunction

endpackage

// File: rtl/box_drawer.sv
// Purpose: paints a BOX_W x BOX_H filled rectangle into the VGA adapter, one pixel per cycle.
// Latency: first pixel 1 cycle after the accepted strobe, draw_done BOX_W*BOX_H+1 cycles after it.
// Backpressure: none downstream; strobes arriving while busy or on the draw_done cycle are dropped.
module box_drawer
    import box_drawer_pkg::*;
#(
    parameter int BOX_W = 8,
    parameter int BOX_H = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               draw,
    input  logic [X_W-1:0]     draw_x,
    input  logic [Y_W-1:0]     draw_y,
    input  logic [COLOR_W-1:0] iColor,
    output logic               draw_done,
    output logic [X_W-1:0]     oX,
    output logic [Y_W-1:0]     oY,
    output logic [COLOR_W-1:0] oColour,
    output logic               plot,
    output logic               busy
);

    localparam int COL_W = cnt_width(BOX_W);
    localparam int ROW_W = cnt_width(BOX_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BOX_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOX_H - 1);

    state_t state_q;
    state_t state_d;

    // Position of the pixel currently presented on oX/oY
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;

    // Request captured at acceptance so later input changes cannot disturb the box
    logic [X_W-1:0]     x_lat_q;
    logic [Y_W-1:0]     y_lat_q;
    logic [COLOR_W-1:0] c_lat_q;

    // Whether the registered pixel is on screen; gates plot
    logic vis_q;

    logic               accept;
    logic               last_pix;
    logic               advance;
    logic               load_pix;
    logic [X_W-1:0]     base_x;
    logic [Y_W-1:0]     base_y;
    logic [COLOR_W-1:0] base_c;
    pix_sum_t           pix_sum;

    // Handshake decode: accept only from idle, step until the last pixel is shown
    always_comb begin
        accept   = (state_q == S_IDLE) && draw;
        last_pix = (state_q == S_DRAW) && (col_q == COL_LAST) && (row_q == ROW_LAST);
        advance  = (state_q == S_DRAW) && !last_pix;
        load_pix = accept || advance;
    end

    // Next pixel: origin taken straight from the inputs on acceptance, from the latches afterwards
    always_comb begin
        base_x = x_lat_q;
        base_y = y_lat_q;
        base_c = c_lat_q;
        col_d  = col_q;
        row_d  = row_q;
        if (accept) begin
            base_x = draw_x;
            base_y = draw_y;
            base_c = iColor;
            col_d  = '0;
            row_d  = '0;
        end else if (advance) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        pix_sum.x = {1'b0, base_x} + (X_W+1)'(col_d);
        pix_sum.y = {1'b0, base_y} + (Y_W+1)'(row_d);
    end

    // Datapath registers: latches, counters and the registered VGA outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            x_lat_q <= '0;
            y_lat_q <= '0;
            c_lat_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            vis_q   <= 1'b0;
        end else begin
            if (accept) begin
                x_lat_q <= draw_x;
                y_lat_q <= draw_y;
                c_lat_q <= iColor;
            end
            if (load_pix) begin
                col_q   <= col_d;
                row_q   <= row_d;
                oX      <= pix_sum.x[X_W-1:0];
                oY      <= pix_sum.y[Y_W-1:0];
                oColour <= base_c;
                vis_q   <= on_screen(pix_sum);
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: idle -> draw on strobe, draw -> done after last pixel, done -> idle
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (draw)     state_d = S_DRAW;
                S_DRAW:  if (last_pix) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; plot and draw_done live in different states so never overlap
    always_comb begin
        busy      = (state_q != S_IDLE);
        draw_done = (state_q == S_DONE);
        plot      = (state_q == S_DRAW) && vis_q;
    end

endmodule

// File: tb/tb_box_drawer.sv
// Purpose: scoreboard bench for box_drawer at 8x8, 1x1 and 16x16 sharing one stimulus stream.
// Latency: expected pixel/done events are timestamped by cycle and checked on arrival.
// Backpressure: n/a.
module tb_box_drawer;

    logic       clock = 1'b0;
    logic       reset;
    logic       draw;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] icol;

    logic       dd [3];
    logic [7:0] ox [3];
    logic [6:0] oy [3];
    logic [2:0] oc [3];
    logic       pl [3];
    logic       bz [3];

    always #5 clock = ~clock;

    box_drawer #(.BOX_W(8), .BOX_H(8)) u_d0 (
        .clock(clock), .reset(reset), .draw(draw), .draw_x(draw_x), .draw_y(draw_y),
        .iColor(icol), .draw_done(dd[0]), .oX(ox[0]), .oY(oy[0]), .oColour(oc[0]),
        .plot(pl[0]), .busy(bz[0]));

    box_drawer #(.BOX_W(1), .BOX_H(1)) u_d1 (
        .clock(clock), .reset(reset), .draw(draw), .draw_x(draw_x), .draw_y(draw_y),
        .iColor(icol), .draw_done(dd[1]), .oX(ox[1]), .oY(oy[1]), .oColour(oc[1]),
        .plot(pl[1]), .busy(bz[1]));

    box_drawer #(.BOX_W(16), .BOX_H(16)) u_d2 (
        .clock(clock), .reset(reset), .draw(draw), .draw_x(draw_x), .draw_y(draw_y),
        .iColor(icol), .draw_done(dd[2]), .oX(ox[2]), .oY(oy[2]), .oColour(oc[2]),
        .plot(pl[2]), .busy(bz[2]));

    int bw [3] = '{8, 1, 16};
    int bh [3] = '{8, 1, 16};

    typedef struct {
        int id;
        int cyc;
        bit is_done;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t sb [$];

    // Busy window per DUT: expected busy for bs <= cycle <= be
    int bs [3] = '{1, 1, 1};
    int be [3] = '{0, 0, 0};

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: a request in cycle N paints pixel i at cycle N+1+i, done at N+W*H+1
    function automatic void model(input bit d, input bit r, input int x, input int y, input int c);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].id == k && sb[i].cyc > cyc) sb.delete(i);
                if (be[k] > cyc) be[k] = cyc;
            end else if (d && cyc > be[k]) begin
                int n;
                n = bw[k] * bh[k];
                for (int i = 0; i < n; i++) begin
                    int px, py;
                    px = x + (i % bw[k]);
                    py = y + (i / bw[k]);
                    if (px < 160 && py < 120)
                        sb.push_back(exp_t'{k, cyc + 1 + i, 1'b0, px, py, c});
                end
                sb.push_back(exp_t'{k, cyc + n + 1, 1'b1, 0, 0, 0});
                bs[k] = cyc + 1;
                be[k] = cyc + n + 1;
            end
        end
    endfunction

    task automatic step(input bit d, input bit r, input int x, input int y, input int c);
        @(posedge clock);
        #1;
        draw   = d;
        reset  = r;
        draw_x = 8'(x);
        draw_y = 7'(y);
        icol   = 3'(c);
        model(d, r, x & 255, y & 127, c & 7);
    endtask

    // Idle cycles with scrambled request data: must not disturb a box in flight
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)));
    endtask

    // Monitor: pop and compare whenever a DUT presents plot or draw_done
    int   m_idx;
    bit   m_busy;
    exp_t m_e;
    always @(negedge clock) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                m_idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].id == k) begin
                        m_idx = i;
                        break;
                    end
                end
                m_busy = (cyc >= bs[k]) && (cyc <= be[k]);
                vectors++;
                if (bz[k] !== m_busy) begin
                    miscompares++;
                    $display("FAIL busy dut%0d cyc %0d: got %b want %b", k, cyc, bz[k], m_busy);
                end
                vectors++;
                if (pl[k] === 1'b1 && dd[k] === 1'b1) begin
                    miscompares++;
                    $display("FAIL plot_and_done dut%0d cyc %0d: got both high want exclusive", k, cyc);
                end
                if (pl[k] !== 1'b0 || dd[k] !== 1'b0) begin
                    vectors++;
                    if (m_idx < 0 || sb[m_idx].cyc != cyc) begin
                        miscompares++;
                        $display("FAIL unexpected dut%0d cyc %0d: got plot=%b done=%b xy=(%0d,%0d) want nothing",
                                 k, cyc, pl[k], dd[k], ox[k], oy[k]);
                    end else begin
                        m_e = sb[m_idx];
                        sb.delete(m_idx);
                        if (m_e.is_done) begin
                            if (dd[k] !== 1'b1 || pl[k] !== 1'b0) begin
                                miscompares++;
                                $display("FAIL done dut%0d cyc %0d: got plot=%b done=%b want plot=0 done=1",
                                         k, cyc, pl[k], dd[k]);
                            end
                        end else if (pl[k] !== 1'b1 || dd[k] !== 1'b0 || int'(ox[k]) != m_e.x ||
                                     int'(oy[k]) != m_e.y || int'(oc[k]) != m_e.c) begin
                            miscompares++;
                            $display("FAIL pixel dut%0d cyc %0d: got plot=%b done=%b (%0d,%0d) c%0d want (%0d,%0d) c%0d",
                                     k, cyc, pl[k], dd[k], ox[k], oy[k], oc[k], m_e.x, m_e.y, m_e.c);
                        end
                    end
                end else if (m_idx >= 0 && sb[m_idx].cyc <= cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL missing dut%0d cyc %0d: got nothing want %s at cyc %0d",
                             k, cyc, sb[m_idx].is_done ? "draw_done" : "plot", sb[m_idx].cyc);
                    sb.delete(m_idx);
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        draw   = 1'b0;
        draw_x = '0;
        draw_y = '0;
        icol   = '0;
        repeat (3) step(1'b0, 1'b1, 0, 0, 0);

        // Reset state of every instance
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ox[k] !== 8'd0 || oy[k] !== 7'd0 || oc[k] !== 3'd0 ||
                pl[k] !== 1'b0 || dd[k] !== 1'b0 || bz[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset dut%0d: got x=%0d y=%0d c=%0d plot=%b done=%b busy=%b want all 0",
                         k, ox[k], oy[k], oc[k], pl[k], dd[k], bz[k]);
            end
        end
        mon_en = 1'b1;
        step(1'b0, 1'b0, 0, 0, 0);

        // Basic draw, right-edge clip, corner overflow
        step(1'b1, 1'b0, 3, 109, 4);
        idle(300);
        step(1'b1, 1'b0, 156, 112, 2);
        idle(300);
        step(1'b1, 1'b0, 255, 127, 5);
        idle(300);

        // Busy collision: strobes at N+10 and on the draw_done cycle N+65
        step(1'b1, 1'b0, 20, 30, 1);
        idle(9);
        step(1'b1, 1'b0, 50, 50, 6);
        idle(54);
        step(1'b1, 1'b0, 70, 70, 3);
        idle(300);

        // Reset during pixel 20, then a fresh draw
        step(1'b1, 1'b0, 40, 40, 7);
        idle(20);
        step(1'b0, 1'b1, 0, 0, 0);
        step(1'b1, 1'b0, 60, 10, 2);
        idle(300);

        // Randomized traffic with edge-biased coordinates and occasional resets
        for (int i = 0; i < 4000; i++) begin
            bit d, r;
            int x, y;
            d = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 299) == 0);
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(145, 160)) : int'($urandom_range(0, 255));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(105, 120)) : int'($urandom_range(0, 127));
            step(d, r, x, y, int'($urandom_range(0, 7)));
        end
        idle(300);

        // Anything still queued was never delivered
        @(negedge clock);
        mon_en = 1'b0;
        foreach (sb[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover dut%0d: got nothing want %s at cyc %0d",
                     sb[i].id, sb[i].is_done ? "draw_done" : "plot", sb[i].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
